// File: rtl/mike_cacheline_adaptor.sv
// Cache-line <-> burst-memory adaptor.
// Splits a LINE_WIDTH cache fill/write-back into BEATS sequential BURST_WIDTH
// memory beats and returns a single-cycle line-level response to the cache.
//
// state | meaning
// IDLE  | waiting for a line read/write request; latches address and write line
// READ  | collecting read beats from memory into line_o
// WRITE | presenting write beats from the latched buffer to memory
// DONE  | one-cycle resp_o pulse to the cache, then back to IDLE
module mike_cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int BEATS       = LINE_WIDTH / BURST_WIDTH,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);

    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]     ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [LINE_WIDTH-1:0]  wbuf;
    logic                   beat_last;

    assign beat_last = resp_i && (cnt == LAST_BEAT);

    // State register; reset abandons any transfer without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; write wins when both requests are up.
    always_comb begin
        state_nxt = state;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (write_i) begin
                    state_nxt = ST_WRITE;
                end else if (read_i) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                read_o = 1'b1;
                if (beat_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                write_o = 1'b1;
                if (beat_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_o    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: address/buffer capture at start, beat counter, fill assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            line_o    <= '0;
            address_o <= '0;
            wbuf      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_i || write_i) begin
                        address_o <= address_i & ADDR_MASK;
                        cnt       <= '0;
                        if (write_i) begin
                            wbuf <= line_i;
                        end
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt == CNT_W'(b)) begin
                                line_o[b*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                            end
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write beat select straight from the counter; quiet outside WRITE.
    always_comb begin
        burst_o = '0;
        if (state == ST_WRITE) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt == CNT_W'(b)) begin
                    burst_o = wbuf[b*BURST_WIDTH +: BURST_WIDTH];
                end
            end
        end
    end

endmodule

// File: doc/mike_cacheline_adaptor.md
Name: mike_cacheline_adaptor

Overview:
- Sits between the cache's 256-bit pmem port and the 64-bit burst physical memory.
- Converts one cache line read into 4 sequential 64-bit beats, and 4 beats back into one line.
- Serialises one 256-bit line write-back into 4 beats.
- Presents a single-cycle line-level response back to the cache controller.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH (4), beats per line; must be a power of two ≥2.
- OFFSET_BITS, 5, low address bits cleared on the memory-side address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- line_i  in  LINE_WIDTH  write-back line from cache (pmem_wdata).
- line_o  out  LINE_WIDTH  assembled fill line to cache (pmem_rdata).
- address_i  in  32  line address from cache (pmem_address).
- read_i  in  1  line read request from cache, level-held until resp_o.
- write_i  in  1  line write request from cache, level-held until resp_o.
- resp_o  out  1  one-cycle completion pulse to cache (pmem_resp).
- burst_i  in  BURST_WIDTH  read beat from memory.
- burst_o  out  BURST_WIDTH  write beat to memory.
- address_o  out  32  memory address, latched and line-aligned.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat-valid / beat-accept strobe.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0, line_o=0, address_o=0, burst_o=0, read_o=write_o=resp_o=0. Reset mid-burst abandons the transfer with no resp_o.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, start of a transfer: latch address_i with low OFFSET_BITS forced to 0 into address_o, clear counter. If write_i is set, latch line_i into a shift buffer. If both read_i and write_i are high, write wins.
- IDLE transitions: write_i=1 -> WRITE; else read_i=1 -> READ; else stay.
- READ:
  - read_o=1.
  - On each cycle with resp_i=1, store burst_i into line_o[counter*BURST_WIDTH +: BURST_WIDTH] and increment counter. Beat 0 is the least-significant 64 bits.
  - Cycles with resp_i=0 are wait states: no change.
  - On the beat with counter==BEATS-1 and resp_i=1 -> DONE; read_o drops in DONE.
- WRITE:
  - write_o=1; burst_o = buffer[counter*BURST_WIDTH +: BURST_WIDTH], combinational from counter.
  - Each resp_i=1 advances counter.
  - Last beat accepted -> DONE.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then -> IDLE unconditionally.
- line_o: holds the full line from the DONE cycle until the next READ overwrites beat 0. It is not cleared between transfers.
- Latency with memory acking every cycle: request seen in IDLE at cycle 0; beats at cycles 1-4; resp_o at cycle 5. Each memory wait cycle adds one.
- A request still high in the cycle after resp_o is treated as a new transfer. The cache controller must drop requests on resp_o.
- address_o, the latched write buffer, and the read/write direction are stable for the whole transfer. Changes on address_i, line_i, read_i or write_i mid-transfer are ignored.
- resp_i in IDLE or DONE is ignored.
- Counter width is log2(BEATS) and wraps to 0 after the last beat.

Test Plan:
- Read fill: address_i=0x0000_1234, read_i=1; memory returns 64'h0..0, 64'h1..1, 64'h2..2, 64'h3..3 on consecutive cycles. Expect address_o=0x0000_1220, read_o high for 4 cycles, resp_o pulses at cycle 5, line_o={3..3,2..2,1..1,0..0}.
- Write-back: line_i=256'hDDDD..CCCC..BBBB..AAAA, write_i=1, address_i=0x8000_00E0. Expect burst_o=AAAA.., BBBB.., CCCC.., DDDD.. in order with write_o high, and one resp_o pulse after the 4th resp_i.
- Wait states: read where resp_i is low for 2 cycles between beats 1 and 2. Expect counter held, line_o correct, resp_o at cycle 7.
- Simultaneous read_i=write_i=1 in IDLE: expect WRITE path (write_o=1, read_o=0). Also change address_i mid-burst: address_o unchanged.
- Reset mid-operation: assert rst=0 after beat 2 of a read. Expect all outputs 0 immediately (async) with no resp_o. After release, a fresh read completes normally with line_o fully refilled.
- Back-to-back: write-back followed by a read raised in the cycle after resp_o. Expect two independent transfers, each with exactly one resp_o pulse, and no beat from the first leaking into the second.
